// File: rtl/gpio_pkg.sv
`default_nettype none
//==============================================================================
// Package : gpio_pkg
// Brief   : Register offsets and APB phase encoding for apb_gpio_ctrl.
// Rev     : 1.0
//==============================================================================
package gpio_pkg;

    localparam logic [31:0] GPIO_ENABLE   = 32'h00;
    localparam logic [31:0] GPIO_DIR      = 32'h04;
    localparam logic [31:0] GPIO_SET      = 32'h08;
    localparam logic [31:0] GPIO_CLR      = 32'h0C;
    localparam logic [31:0] GPIO_OUT      = 32'h10;
    localparam logic [31:0] GPIO_IN       = 32'h14;
    localparam logic [31:0] GPIO_RISE_EN  = 32'h18;
    localparam logic [31:0] GPIO_FALL_EN  = 32'h1C;
    localparam logic [31:0] GPIO_IRQ_STAT = 32'h20;

    localparam int APB_STATE_W = 2;
    localparam logic [APB_STATE_W-1:0] IDLE   = 2'd0;
    localparam logic [APB_STATE_W-1:0] SETUP  = 2'd1;
    localparam logic [APB_STATE_W-1:0] ACCESS = 2'd2;

endpackage
`default_nettype wire

// File: rtl/apb_gpio_ctrl_if.sv
`default_nettype none
//==============================================================================
// Interface : apb_gpio_ctrl_if
// Brief     : APB3 bus bundle with master and slave views.
// Rev       : 1.0
//==============================================================================
interface apb_gpio_ctrl_if #(
    parameter int ADDR_W = 6
) ();
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface
`default_nettype wire

// File: rtl/gpio_sync.sv
`default_nettype none
//==============================================================================
// Module : gpio_sync
// Brief  : W-bit multi-flop synchroniser, async active-low reset.
// Rev    : 1.0
//==============================================================================
module gpio_sync #(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic [W-1:0] i_d,
    output logic      [W-1:0] o_q
);
    logic [W-1:0] r_stage [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[STAGES-1];
endmodule
`default_nettype wire

// File: rtl/apb_gpio_ctrl.sv
`default_nettype none
//==============================================================================
// Module : apb_gpio_ctrl
// Brief  : APB3 GPIO controller with set/clear aliases and edge interrupts.
// Rev    : 1.0
//==============================================================================
module apb_gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int NPINS       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 6
) (
    input  wire logic             PCLK,
    input  wire logic             PRESETn,
    apb_gpio_ctrl_if.slave        apb,
    input  wire logic [NPINS-1:0] gpio_in,
    output logic      [NPINS-1:0] gpio_out,
    output logic      [NPINS-1:0] gpio_oe,
    output logic                  irq
);
    logic [APB_STATE_W-1:0] r_state, w_state_nxt;
    logic [NPINS-1:0] w_sync, r_prev, w_in, w_mask, w_hw_set, w_w1c, w_wdata;
    logic [NPINS-1:0] r_enable, r_dir, r_out, r_rise_en, r_fall_en, r_irq_stat;
    logic [31:0]      w_off, w_rdata, r_prdata;
    logic             w_err, w_wr, w_rd_cap, w_slverr, w_unused;

    gpio_sync #(.W(NPINS), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .i_d   (gpio_in),
        .o_q   (w_sync)
    );

    assign w_off    = 32'({apb.PADDR[ADDR_W-1:2], 2'b00});
    assign w_wdata  = apb.PWDATA[NPINS-1:0];
    assign w_unused = ^{apb.PADDR[1:0], apb.PWDATA};

    // r_state is the phase of the cycle just completed; w_state_nxt is the
    // phase of the current bus cycle, so commits happen at the edge ending it.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            SETUP:   w_state_nxt = ACCESS;
            default: if (apb.PSEL && !apb.PENABLE) w_state_nxt = SETUP;
        endcase
    end

    always_comb begin
        w_wr     = (w_state_nxt == ACCESS) && apb.PSEL && apb.PENABLE && apb.PWRITE && !w_err;
        w_rd_cap = (w_state_nxt == SETUP) && !apb.PWRITE;
        w_slverr = (w_state_nxt == ACCESS) && apb.PSEL && w_err;
    end

    assign w_err = (w_off > GPIO_IRQ_STAT)
                || (apb.PWRITE && (w_off == GPIO_IN))
                || (!apb.PWRITE && ((w_off == GPIO_SET) || (w_off == GPIO_CLR)));

    assign w_in = w_sync & r_enable & ~r_dir;

    always_comb begin
        w_rdata = '0;
        case (w_off)
            GPIO_ENABLE:   w_rdata = 32'(r_enable);
            GPIO_DIR:      w_rdata = 32'(r_dir);
            GPIO_OUT:      w_rdata = 32'(r_out);
            GPIO_IN:       w_rdata = 32'(w_in);
            GPIO_RISE_EN:  w_rdata = 32'(r_rise_en);
            GPIO_FALL_EN:  w_rdata = 32'(r_fall_en);
            GPIO_IRQ_STAT: w_rdata = 32'(r_irq_stat);
            default:       w_rdata = '0;
        endcase
    end

    assign w_mask   = r_enable & ~r_dir;
    assign w_hw_set = ((w_sync & ~r_prev & r_rise_en) | (~w_sync & r_prev & r_fall_en)) & w_mask;
    assign w_w1c    = (w_wr && (w_off == GPIO_IRQ_STAT)) ? w_wdata : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_enable   <= '0;
            r_dir      <= '0;
            r_out      <= '0;
            r_rise_en  <= '0;
            r_fall_en  <= '0;
            r_irq_stat <= '0;
            r_prev     <= '0;
            r_prdata   <= '0;
        end else begin
            r_prev     <= w_sync;
            // hardware set takes priority over a same-cycle W1C
            r_irq_stat <= (r_irq_stat & ~w_w1c) | w_hw_set;
            if (w_rd_cap) r_prdata <= w_rdata;
            if (w_wr) begin
                case (w_off)
                    GPIO_ENABLE:  r_enable  <= w_wdata;
                    GPIO_DIR:     r_dir     <= w_wdata;
                    GPIO_SET:     r_out     <= r_out | w_wdata;
                    GPIO_CLR:     r_out     <= r_out & ~w_wdata;
                    GPIO_OUT:     r_out     <= w_wdata;
                    GPIO_RISE_EN: r_rise_en <= w_wdata;
                    GPIO_FALL_EN: r_fall_en <= w_wdata;
                    default:      ;
                endcase
            end
        end
    end

    assign apb.PRDATA  = r_prdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = w_slverr;
    assign gpio_out    = r_out & r_enable;
    assign gpio_oe     = r_enable & r_dir;
    assign irq         = |r_irq_stat;
endmodule
`default_nettype wire

// File: tb/tb_apb_gpio_ctrl.sv
`default_nettype none
//==============================================================================
// Module : tb_apb_gpio_ctrl
// Brief  : Self-checking bench for apb_gpio_ctrl with a behavioural model.
// Rev    : 1.0
//==============================================================================
module tb_apb_gpio_ctrl;
    localparam int NPINS = 8;
    localparam int SYNC_STAGES = 2;
    localparam int ADDR_W = 6;

    logic clk = 1'b0;
    logic rst_n;
    logic [NPINS-1:0] gpio_in, gpio_out, gpio_oe;
    logic irq;
    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    apb_gpio_ctrl_if #(.ADDR_W(ADDR_W)) apb ();

    apb_gpio_ctrl #(.NPINS(NPINS), .SYNC_STAGES(SYNC_STAGES), .ADDR_W(ADDR_W)) dut (
        .PCLK     (clk),
        .PRESETn  (rst_n),
        .apb      (apb),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_en, m_dir, m_out, m_rise, m_fall, m_stat, m_prev;
    logic [7:0]  m_sh [SYNC_STAGES];
    logic        m_was_setup;
    logic [31:0] m_rdata;

    function automatic logic [31:0] offs(input logic [5:0] a);
        return {26'b0, a[5:2], 2'b00};
    endfunction

    function automatic logic m_err(input logic [5:0] a, input logic wr);
        logic [31:0] o;
        o = offs(a);
        return (o > 32'h20) || (wr && o == 32'h14) || (!wr && (o == 32'h08 || o == 32'h0C));
    endfunction

    function automatic logic [31:0] m_read(input logic [5:0] a);
        case (offs(a))
            32'h00:  return {24'b0, m_en};
            32'h04:  return {24'b0, m_dir};
            32'h10:  return {24'b0, m_out};
            32'h14:  return {24'b0, m_sh[SYNC_STAGES-1] & m_en & ~m_dir};
            32'h18:  return {24'b0, m_rise};
            32'h1C:  return {24'b0, m_fall};
            32'h20:  return {24'b0, m_stat};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin : p_model
        logic [7:0] s, hw, w1c, d;
        if (!rst_n) begin
            m_en = 0; m_dir = 0; m_out = 0; m_rise = 0; m_fall = 0; m_stat = 0; m_prev = 0;
            for (int i = 0; i < SYNC_STAGES; i++) m_sh[i] = 0;
            m_was_setup = 0;
            m_rdata = 0;
        end else begin
            s   = m_sh[SYNC_STAGES-1];
            hw  = ((s & ~m_prev & m_rise) | (~s & m_prev & m_fall)) & m_en & ~m_dir;
            w1c = 0;
            d   = apb.PWDATA[7:0];
            if (apb.PSEL && !apb.PENABLE && !apb.PWRITE) m_rdata = m_read(apb.PADDR);
            if (m_was_setup && apb.PSEL && apb.PENABLE && apb.PWRITE && !m_err(apb.PADDR, 1'b1)) begin
                case (offs(apb.PADDR))
                    32'h00: m_en = d;
                    32'h04: m_dir = d;
                    32'h08: m_out = m_out | d;
                    32'h0C: m_out = m_out & ~d;
                    32'h10: m_out = d;
                    32'h18: m_rise = d;
                    32'h1C: m_fall = d;
                    32'h20: w1c = d;
                    default: ;
                endcase
            end
            m_stat = (m_stat & ~w1c) | hw;
            m_prev = s;
            for (int i = SYNC_STAGES-1; i > 0; i--) m_sh[i] = m_sh[i-1];
            m_sh[0] = gpio_in;
            m_was_setup = apb.PSEL && !apb.PENABLE;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_gpio_out", 32'(gpio_out), 32'(m_out & m_en));
            check("model_gpio_oe",  32'(gpio_oe),  32'(m_en & m_dir));
            check("model_irq",      32'(irq),      32'(|m_stat));
            if (m_was_setup && apb.PSEL && apb.PENABLE) begin
                check("model_pslverr", 32'(apb.PSLVERR), 32'(m_err(apb.PADDR, apb.PWRITE)));
                if (!apb.PWRITE) check("model_prdata", apb.PRDATA, m_rdata);
            end else begin
                check("model_pslverr_idle", 32'(apb.PSLVERR), 32'h0);
            end
        end
    end

    // ---------------- bus tasks (entered #1 after a rising edge) ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [5:0] a, input logic [31:0] d, output logic e);
        apb.PSEL = 1; apb.PENABLE = 0; apb.PWRITE = 1; apb.PADDR = a; apb.PWDATA = d;
        @(posedge clk); #1 apb.PENABLE = 1;
        @(negedge clk); e = apb.PSLVERR;
        @(posedge clk); #1 apb.PSEL = 0; apb.PENABLE = 0;
    endtask

    task automatic apb_read(input logic [5:0] a, output logic [31:0] d, output logic e);
        apb.PSEL = 1; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = a;
        @(posedge clk); #1 apb.PENABLE = 1;
        @(negedge clk); d = apb.PRDATA; e = apb.PSLVERR;
        @(posedge clk); #1 apb.PSEL = 0; apb.PENABLE = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        rst_n = 0;
        apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = '0; apb.PWDATA = '0;
        gpio_in = '0;
        tick(3);
        rst_n = 1;
        tick(1);

        // 1. reset state
        for (int a = 0; a <= 32; a += 4) begin
            apb_read(6'(a), rd, e);
            check("reset_rd", rd, 32'h0);
            check("reset_err", 32'(e), 32'((a == 8) || (a == 12)));
        end
        check("reset_oe", 32'(gpio_oe), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        check("pready", 32'(apb.PREADY), 32'h1);

        // 2. output path with set/clear aliases
        apb_write(6'h00, 32'hFF, e);
        apb_write(6'h04, 32'h0F, e);
        apb_write(6'h10, 32'h05, e);
        apb_write(6'h08, 32'h0A, e);
        apb_write(6'h0C, 32'h01, e);
        check("out_err", 32'(e), 32'h0);
        check("oe_0f", 32'(gpio_oe), 32'h0F);
        apb_read(6'h10, rd, e);
        check("out_rd_0e", rd, 32'h0E);
        check("gpio_out_0e", 32'(gpio_out), 32'h0E);

        // 3. rising edge latency and W1C
        apb_write(6'h04, 32'h00, e);
        apb_write(6'h18, 32'h01, e);
        gpio_in = 8'h01;
        tick(1); check("irq_e1", 32'(irq), 32'h0);
        tick(1); check("irq_e2", 32'(irq), 32'h0);
        tick(1); check("irq_e3", 32'(irq), 32'h1);
        apb_read(6'h14, rd, e);
        check("in_rd", rd, 32'h01);
        apb_write(6'h20, 32'h01, e);
        check("irq_w1c", 32'(irq), 32'h0);

        // 4. hardware set collides with W1C
        gpio_in = 8'h00;
        tick(4);
        check("irq_no_fall", 32'(irq), 32'h0);
        gpio_in = 8'h01;
        tick(1);
        apb_write(6'h20, 32'h01, e);
        check("irq_set_wins", 32'(irq), 32'h1);
        apb_read(6'h20, rd, e);
        check("stat_set_wins", rd, 32'h01);

        // falling edge, then DIR masks new edges but keeps pending bits
        apb_write(6'h1C, 32'h02, e);
        gpio_in = 8'h03; tick(4);
        gpio_in = 8'h01; tick(4);
        apb_read(6'h20, rd, e);
        check("stat_fall", rd, 32'h03);
        apb_write(6'h04, 32'h02, e);
        check("oe_dir", 32'(gpio_oe), 32'h02);
        gpio_in = 8'h03; tick(4);
        gpio_in = 8'h01; tick(4);
        apb_read(6'h20, rd, e);
        check("stat_dir_keep", rd, 32'h03);
        apb_write(6'h20, 32'h03, e);
        check("irq_clr_all", 32'(irq), 32'h0);
        apb_read(6'h20, rd, e);
        check("stat_clr_all", rd, 32'h0);

        // 5. error responses
        apb_write(6'h14, 32'hFF, e);
        check("err_wr_in", 32'(e), 32'h1);
        apb_read(6'h24, rd, e);
        check("err_rd_unmapped", 32'(e), 32'h1);
        check("rd_unmapped_data", rd, 32'h0);
        apb_read(6'h14, rd, e);
        check("in_unchanged", rd, 32'h01);
        check("in_rd_ok", 32'(e), 32'h0);

        // 6. reset during the access phase of a write
        apb.PSEL = 1; apb.PENABLE = 0; apb.PWRITE = 1; apb.PADDR = 6'h10; apb.PWDATA = 32'hFF;
        @(posedge clk); #1 apb.PENABLE = 1;
        #2 rst_n = 0;
        @(posedge clk); #1 apb.PSEL = 0; apb.PENABLE = 0;
        tick(1);
        rst_n = 1;
        check("rst_gpio_out", 32'(gpio_out), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        apb_read(6'h10, rd, e);
        check("rst_out_rd", rd, 32'h0);
        apb_write(6'h00, 32'hFF, e);
        apb_write(6'h10, 32'h3C, e);
        check("post_rst_err", 32'(e), 32'h0);
        apb_read(6'h10, rd, e);
        check("post_rst_out", rd, 32'h3C);
        check("post_rst_gpio_out", 32'(gpio_out), 32'h3C);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire
